// File: rtl/data_memory_responder_if.sv
// Request/response bus between a load/store initiator and the data memory
// responder.
//
// Handshake: a request transfers on the rising edge where request_valid and
// request_ready are both 1. The request fields (request_write,
// data_mem_address, data_mem_write_data, data_mem_format) are captured on
// that edge. request_valid seen while request_ready is 0 is ignored. The
// response is a single-cycle response_valid pulse with no backpressure.
// data_mem_data_fetched and response_error are only meaningful while
// response_valid is 1 and are driven to 0 otherwise.
interface data_memory_responder_if;
    logic        request_valid;
    logic        request_ready;
    logic        request_write;
    logic [31:0] data_mem_address;
    logic [31:0] data_mem_write_data;
    logic [2:0]  data_mem_format;
    logic        response_valid;
    logic [31:0] data_mem_data_fetched;
    logic        response_error;

    modport master (
        output request_valid, request_write, data_mem_address,
               data_mem_write_data, data_mem_format,
        input  request_ready, response_valid, data_mem_data_fetched,
               response_error
    );

    modport slave (
        input  request_valid, request_write, data_mem_address,
               data_mem_write_data, data_mem_format,
        output request_ready, response_valid, data_mem_data_fetched,
               response_error
    );
endinterface

// File: rtl/data_memory_responder.sv
// Byte-addressable, little-endian data memory with a fixed-latency
// request/response protocol. One request is in flight at a time; the response
// pulse arrives WAIT_STATES+1 cycles after the acceptance edge. Stores commit
// on the edge that enters the response state.
module data_memory_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    data_memory_responder_if.slave bus,
    output logic [1:0]             state_dbg
);
    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [2:0] FMT_B  = 3'b000;
    localparam logic [2:0] FMT_H  = 3'b001;
    localparam logic [2:0] FMT_W  = 3'b010;
    localparam logic [2:0] FMT_BU = 3'b100;
    localparam logic [2:0] FMT_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  fmt_q, fmt_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_error_q, resp_error_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem_q [DEPTH];

    // Request currently being worked on: the live bus fields while idle (so a
    // zero-wait request can complete on its acceptance edge), else the capture.
    logic        cur_write;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [2:0]  cur_fmt;

    assign cur_write = (state_q == S_IDLE) ? bus.request_write       : write_q;
    assign cur_addr  = (state_q == S_IDLE) ? bus.data_mem_address    : addr_q;
    assign cur_wdata = (state_q == S_IDLE) ? bus.data_mem_write_data : wdata_q;
    assign cur_fmt   = (state_q == S_IDLE) ? bus.data_mem_format     : fmt_q;

    // Address bits above the array size alias; they are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^cur_addr[31:ADDR_WIDTH+2];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic [31:0]           word_rd;
    logic [31:0]           lane_rd;
    logic [31:0]           load_data;
    logic [31:0]           store_data;
    logic [3:0]            byte_en;
    logic                  fmt_bad;
    logic                  misaligned;
    logic                  store_bad;
    logic                  req_error;
    logic                  enter_resp;
    logic                  commit;

    // Decode the format: load extraction, store lane enables, error detection.
    always_comb begin
        word_idx   = cur_addr[ADDR_WIDTH+1:2];
        lane       = cur_addr[1:0];
        word_rd    = mem_q[word_idx];
        lane_rd    = word_rd >> {lane, 3'b000};
        load_data  = 32'd0;
        store_data = 32'd0;
        byte_en    = 4'b0000;
        fmt_bad    = 1'b0;
        misaligned = 1'b0;
        case (cur_fmt)
            FMT_B: begin
                load_data  = {{24{lane_rd[7]}}, lane_rd[7:0]};
                byte_en    = 4'b0001 << lane;
                store_data = {4{cur_wdata[7:0]}};
            end
            FMT_BU: begin
                load_data = {24'd0, lane_rd[7:0]};
            end
            FMT_H: begin
                misaligned = lane[0];
                load_data  = {{16{lane_rd[15]}}, lane_rd[15:0]};
                byte_en    = 4'b0011 << lane;
                store_data = {2{cur_wdata[15:0]}};
            end
            FMT_HU: begin
                misaligned = lane[0];
                load_data  = {16'd0, lane_rd[15:0]};
            end
            FMT_W: begin
                misaligned = (lane != 2'b00);
                load_data  = word_rd;
                byte_en    = 4'b1111;
                store_data = cur_wdata;
            end
            default: begin
                fmt_bad = 1'b1;
            end
        endcase
        store_bad = cur_write && ((cur_fmt == FMT_BU) || (cur_fmt == FMT_HU));
        req_error = fmt_bad | misaligned | store_bad;
    end

    // Next-state logic: accept in idle, count wait states, pulse the response.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        fmt_d        = fmt_q;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        rdata_d      = 32'd0;
        enter_resp   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.request_valid) begin
                    write_d = bus.request_write;
                    addr_d  = bus.data_mem_address;
                    wdata_d = bus.data_mem_write_data;
                    fmt_d   = bus.data_mem_format;
                    if (WAIT_STATES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (enter_resp) begin
            resp_valid_d = 1'b1;
            resp_error_d = req_error;
            rdata_d      = (req_error || cur_write) ? 32'd0 : load_data;
        end
    end

    // Reset beats the commit, so a store pending in WAIT is dropped.
    assign commit = enter_resp && cur_write && !req_error && !reset;

    // FSM state, captured request and registered response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            fmt_q        <= FMT_W;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            rdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            fmt_q        <= fmt_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            rdata_q      <= rdata_d;
        end
    end

    // Memory array: byte-lane writes on commit, contents survive reset.
    always_ff @(posedge clock) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem_q[word_idx][8*i +: 8] <= store_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.request_ready         = (state_q == S_IDLE);
    assign bus.response_valid        = resp_valid_q;
    assign bus.response_error        = resp_error_q;
    assign bus.data_mem_data_fetched = rdata_q;
    assign state_dbg                 = state_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (WAIT_STATES=2 and 0) share
// one clock. A byte-level memory model follows every accepted request and is
// compared to the outputs of both instances on every cycle.
module tb_data_memory_responder;
  localparam int WS0 = 2;
  localparam int WS1 = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst [2];
  logic        rv  [2];
  logic        rw  [2];
  logic [31:0] ad  [2];
  logic [31:0] wdt [2];
  logic [2:0]  fm  [2];
  logic        rdy [2];
  logic        vld [2];
  logic [31:0] rdd [2];
  logic        rer [2];
  logic [1:0]  st0, st1;

  data_memory_responder_if ifa ();
  data_memory_responder_if ifb ();

  assign ifa.request_valid       = rv[0];
  assign ifa.request_write       = rw[0];
  assign ifa.data_mem_address    = ad[0];
  assign ifa.data_mem_write_data = wdt[0];
  assign ifa.data_mem_format     = fm[0];
  assign rdy[0] = ifa.request_ready;
  assign vld[0] = ifa.response_valid;
  assign rdd[0] = ifa.data_mem_data_fetched;
  assign rer[0] = ifa.response_error;

  assign ifb.request_valid       = rv[1];
  assign ifb.request_write       = rw[1];
  assign ifb.data_mem_address    = ad[1];
  assign ifb.data_mem_write_data = wdt[1];
  assign ifb.data_mem_format     = fm[1];
  assign rdy[1] = ifb.request_ready;
  assign vld[1] = ifb.response_valid;
  assign rdd[1] = ifb.data_mem_data_fetched;
  assign rer[1] = ifb.response_error;

  data_memory_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS0)) dut_a (
    .clock(clk), .reset(rst[0]), .bus(ifa), .state_dbg(st0)
  );
  data_memory_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS1)) dut_b (
    .clock(clk), .reset(rst[1]), .bus(ifb), .state_dbg(st1)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, required %h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mb [2][4096];

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return 32'(i + 1) * 32'h9E3779B9;
  endfunction

  // Executes one request against the byte model; stores update it.
  function automatic void model_exec(input int d, input logic wr, input logic [31:0] a,
                                     input logic [31:0] wd, input logic [2:0] f,
                                     output logic [31:0] data, output logic err);
    int size;
    bit sgn;
    bit legal;
    logic [31:0] val;
    logic [11:0] bi;
    legal = 1'b1;
    sgn   = 1'b0;
    size  = 1;
    case (f)
      3'b000: begin size = 1; sgn = 1'b1; end
      3'b001: begin size = 2; sgn = 1'b1; end
      3'b010: begin size = 4; end
      3'b100: begin size = 1; end
      3'b101: begin size = 2; end
      default: legal = 1'b0;
    endcase
    err = !legal || ((a[1:0] & 2'(size - 1)) != 2'b00) || (wr && f[2]);
    data = 32'd0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < size; i++) begin
          bi = a[11:0] + 12'(i);
          mb[d][bi] = 8'(wd >> (8 * i));
        end
      end else begin
        val = 32'd0;
        for (int i = 0; i < size; i++) begin
          bi = a[11:0] + 12'(i);
          val = val | (32'(mb[d][bi]) << (8 * i));
        end
        if (sgn && val[8 * size - 1]) val = val | (32'hFFFF_FFFF << (8 * size));
        data = val;
      end
    end
  endfunction

  // ---------------- compare process ----------------
  bit          pend_v   [2];
  int          pend_due [2];
  logic        pend_wr  [2];
  logic [31:0] pend_a   [2];
  logic [31:0] pend_wd  [2];
  logic [2:0]  pend_f   [2];
  int          free_c   [2];

  initial begin
    logic [31:0] md;
    logic me;
    bit exp_rdy;
    for (int d = 0; d < 2; d++) begin
      pend_v[d] = 1'b0;
      free_c[d] = 1;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        exp_rdy = (cyc >= free_c[d]);
        chk($sformatf("dut%0d_request_ready", d), 32'(rdy[d]), 32'(exp_rdy));
        if (pend_v[d] && pend_due[d] == cyc) begin
          model_exec(d, pend_wr[d], pend_a[d], pend_wd[d], pend_f[d], md, me);
          pend_v[d] = 1'b0;
          chk($sformatf("dut%0d_response_valid", d), 32'(vld[d]), 32'd1);
          chk($sformatf("dut%0d_data_fetched", d), rdd[d], md);
          chk($sformatf("dut%0d_response_error", d), 32'(rer[d]), 32'(me));
        end else begin
          chk($sformatf("dut%0d_idle_valid", d), 32'(vld[d]), 32'd0);
          chk($sformatf("dut%0d_idle_data", d), rdd[d], 32'd0);
          chk($sformatf("dut%0d_idle_error", d), 32'(rer[d]), 32'd0);
        end
        if (rst[d]) begin
          pend_v[d] = 1'b0;
          free_c[d] = cyc + 1;
        end else if (rv[d] && exp_rdy) begin
          pend_v[d]   = 1'b1;
          pend_due[d] = cyc + 1 + ws_of(d);
          pend_wr[d]  = rw[d];
          pend_a[d]   = ad[d];
          pend_wd[d]  = wdt[d];
          pend_f[d]   = fm[d];
          free_c[d]   = cyc + 2 + ws_of(d);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after a rising edge.
  task automatic issue(input int d, input logic wr, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic re, output int lat);
    int t_acc;
    bit got;
    rv[d] = 1'b1; rw[d] = wr; fm[d] = f; ad[d] = a; wdt[d] = wd;
    rd = 32'd0; re = 1'b0; lat = -1; t_acc = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy[d] === 1'b1) begin
        t_acc = cyc + 1;
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    rv[d] = 1'b0;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL dut%0d_accept_timeout: request_ready=%b, required 1 within 40 cycles", d, rdy[d]);
      return;
    end
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (vld[d] === 1'b1) begin
        rd = rdd[d]; re = rer[d]; lat = cyc - t_acc;
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL dut%0d_response_timeout: response_valid=%b, required 1 within 40 cycles", d, vld[d]);
    end
    @(posedge clk); #1;
  endtask

  task automatic xact(input string nm, input int d, input logic wr, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] rd;
    logic re;
    int lat;
    exp_q.push_back(exp_d);
    issue(d, wr, f, a, wd, rd, re, lat);
    chk({nm, "_data"}, rd, exp_q.pop_front());
    chk({nm, "_err"}, 32'(re), 32'(exp_e));
    chk({nm, "_latency"}, lat, ws_of(d));
  endtask

  task automatic drive_random(input int d);
    rv[d]  = ($urandom_range(0, 2) != 0);
    rw[d]  = 1'($urandom_range(0, 1));
    fm[d]  = 3'($urandom_range(0, 7));
    ad[d]  = $urandom() & 32'hFFFF_F03F;
    wdt[d] = $urandom();
    rst[d] = ($urandom_range(0, 59) == 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] md;
    logic me;
    bit seen;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rv[d] = 1'b0; rw[d] = 1'b0;
      ad[d] = 32'd0; wdt[d] = 32'd0; fm[d] = 3'b010;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Fill words 0..15 of both memories with a known pattern.
    for (int i = 0; i < 16; i++) begin
      xact("init_a", 0, 1'b1, 3'b010, 32'(i * 4), init_word(i), 32'd0, 1'b0);
      xact("init_b", 1, 1'b1, 3'b010, 32'(i * 4), init_word(i), 32'd0, 1'b0);
    end

    // Store/load round trip with latency and ready recovery.
    xact("sw_deadbeef", 0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    chk("ready_after_resp", 32'(rdy[0]), 32'd1);
    xact("lw_10", 0, 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

    // Sub-word loads with sign/zero extension.
    xact("lb_13", 0, 1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFFFFDE, 1'b0);
    xact("lbu_13", 0, 1'b0, 3'b100, 32'h13, 32'd0, 32'h000000DE, 1'b0);
    xact("lh_12", 0, 1'b0, 3'b001, 32'h12, 32'd0, 32'hFFFFDEAD, 1'b0);
    xact("lhu_10", 0, 1'b0, 3'b101, 32'h10, 32'd0, 32'h0000BEEF, 1'b0);
    model_exec(0, 1'b0, 32'h13, 32'd0, 3'b000, md, me);
    chk("model_lb_13", md, 32'hFFFFFFDE);
    model_exec(0, 1'b0, 32'h10, 32'd0, 3'b101, md, me);
    chk("model_lhu_10", md, 32'h0000BEEF);

    // Sub-word stores touch only their lanes.
    xact("sb_11", 0, 1'b1, 3'b000, 32'h11, 32'h00000055, 32'd0, 1'b0);
    xact("lw_after_sb", 0, 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEAD55EF, 1'b0);
    xact("sh_12", 0, 1'b1, 3'b001, 32'h12, 32'h00001234, 32'd0, 1'b0);
    xact("lw_after_sh", 0, 1'b0, 3'b010, 32'h10, 32'd0, 32'h123455EF, 1'b0);

    // Error cases leave memory alone.
    xact("lw_misaligned", 0, 1'b0, 3'b010, 32'h12, 32'd0, 32'd0, 1'b1);
    xact("sh_misaligned", 0, 1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, 32'd0, 1'b1);
    xact("fmt_011", 0, 1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 1'b1);
    xact("sbu_store", 0, 1'b1, 3'b100, 32'h10, 32'h000000AA, 32'd0, 1'b1);
    xact("lw_unchanged", 0, 1'b0, 3'b010, 32'h10, 32'd0, 32'h123455EF, 1'b0);

    // Reset during WAIT drops a pending store; a request held during reset is not taken.
    rv[0] = 1'b1; rw[0] = 1'b1; fm[0] = 3'b010; ad[0] = 32'h20; wdt[0] = 32'hCAFEF00D;
    @(negedge clk);
    chk("rst_wait_ready_before", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1;
    rst[0] = 1'b1; wdt[0] = 32'h0BAD0BAD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[0] = 1'b0; rv[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vld[0] === 1'b1) seen = 1'b1;
    end
    chk("rst_wait_no_pulse", 32'(seen), 32'd0);
    @(posedge clk); #1;
    xact("lw_20_after_rst", 0, 1'b0, 3'b010, 32'h20, 32'd0, init_word(8), 1'b0);

    // Zero wait states and address aliasing.
    xact("ws0_sw_0", 1, 1'b1, 3'b010, 32'h0, 32'h11111111, 32'd0, 1'b0);
    xact("ws0_lw_1000", 1, 1'b0, 3'b010, 32'h1000, 32'd0, 32'h11111111, 1'b0);

    // Randomized traffic on both instances, inputs changing every cycle.
    for (int n = 0; n < 1500; n++) begin
      drive_random(0);
      drive_random(1);
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; rv[d] = 1'b0;
    end
    repeat (10) @(posedge clk);
    #1;
    xact("final_lw_20_ws2", 0, 1'b0, 3'b010, 32'h20, 32'd0, {mb[0][12'h23], mb[0][12'h22], mb[0][12'h21], mb[0][12'h20]}, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, is the word-address width; capacity is 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_STATES, default 1, sets the extra cycles between request acceptance and response (0..15).
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 request_valid  input  1  initiator presents a request.
REQ-006 request_ready  output  1  responder can accept a request.
REQ-007 request_write  input  1  1 = store, 0 = load.
REQ-008 data_mem_address  input  32  byte address.
REQ-009 data_mem_write_data  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-010 data_mem_format  input  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 response_valid  output  1  one-cycle pulse marking completion of the accepted request.
REQ-012 data_mem_data_fetched  output  32  load result, valid only while response_valid=1.
REQ-013 response_error  output  1  request was misaligned or had an illegal format; valid only with response_valid.

Function
REQ-014 States: IDLE, WAIT, RESP; request_ready SHALL be 1 only in IDLE.
REQ-015 Acceptance SHALL occur on the edge where request_valid=1 and request_ready=1; address, write data, format and request_write SHALL be captured on that edge.
REQ-016 Transition on acceptance: to WAIT with the counter loaded with WAIT_STATES-1 if WAIT_STATES>0; otherwise directly to RESP.
REQ-017 WAIT SHALL decrement the counter each cycle and move to RESP on the edge where the counter is 0.
REQ-018 RESP SHALL last exactly one cycle with response_valid=1, then return to IDLE; there is no response backpressure.
REQ-019 Latency: response_valid SHALL be high in the (WAIT_STATES+1)th cycle after the acceptance edge; back-to-back throughput is one request per WAIT_STATES+2 cycles.
REQ-020 The memory array is little-endian and byte-addressable; word index = address[ADDR_WIDTH+1:2]; upper address bits are ignored (aliasing wrap-around).
REQ-021 Loads: select lane by address[1:0]; B/H sign-extend, BU/HU zero-extend, W returns the full word.
REQ-022 Stores: only the addressed byte(s) are modified (B: 1 lane, H: 2 lanes, W: 4 lanes); BU/HU with request_write=1 are illegal.
REQ-023 Store commit SHALL occur on the edge entering RESP, never earlier.
REQ-024 Error cases: H/HU with address[0]=1; W with address[1:0]≠00; format 011, 110, 111; BU/HU store. On error, response_error=1, data_mem_data_fetched=0, and no memory write.
REQ-025 When response_valid=0, data_mem_data_fetched and response_error SHALL be 0.
REQ-026 For store responses, data_mem_data_fetched SHALL be 0.
REQ-027 A load in the request immediately following a store to the same address SHALL return the stored data.
REQ-028 request_valid while not in IDLE SHALL be ignored (no capture, no state change).

Reset
REQ-029 With reset high at an edge: state becomes IDLE, counter 0, response_valid=0, response_error=0, data_mem_data_fetched=0; request_ready=1 in the first cycle after reset deasserts.
REQ-030 Reset SHALL take priority over acceptance on the same edge; that request is not accepted.
REQ-031 Reset in WAIT SHALL drop the pending request; a pending store is not committed.
REQ-032 Memory contents are not cleared by reset.

Verification
REQ-033 WAIT_STATES=2: SW 0xDEADBEEF @0x10 accepted at edge N -> response_valid high only in the cycle after edge N+2, then request_ready=1 again; LW @0x10 -> 0xDEADBEEF, error=0.
REQ-034 With word 0xDEADBEEF @0x10: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
REQ-035 SB 0x00000055 @0x11, then LW @0x10 -> 0xDEAD55EF; SH 0x1234 @0x12, then LW -> 0x123455EF.
REQ-036 LW @0x12, SH @0x11, and format 011 -> response_error=1, data 0; a subsequent LW @0x10 shows memory unchanged.
REQ-037 SW 0xCAFEF00D @0x20 accepted, reset asserted during WAIT -> no response pulse; after reset, LW @0x20 returns the prior contents; request_valid held during reset is not accepted.
REQ-038 WAIT_STATES=0, ADDR_WIDTH=10: SW 0x11111111 @0x0 then LW @0x1000 (alias) -> 0x11111111 with response_valid in the cycle after each acceptance edge.
